// File: rtl/counter_ctrl_pkg.sv
// Shared encodings and count-step helper
// for the button-driven counter sequencer.
package counter_ctrl_pkg;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef struct packed {
    logic [31:0] val;
    logic        wrap;
    logic        done;
  } step_t;

  // One count update: +/-1, wrapping or
  // saturating at 0 and max.
  function automatic step_t next_count(
    input logic [31:0] val,
    input logic [31:0] max,
    input logic        up,
    input logic        wrap_en
  );
    step_t r;
    r.val  = val;
    r.wrap = 1'b0;
    r.done = 1'b0;
    if (up) begin
      if (val == max) begin
        if (wrap_en) begin
          r.val  = '0;
          r.wrap = 1'b1;
        end else begin
          r.done = 1'b1;
        end
      end else begin
        r.val = val + 32'd1;
      end
    end else begin
      if (val == '0) begin
        if (wrap_en) begin
          r.val  = max;
          r.wrap = 1'b1;
        end else begin
          r.done = 1'b1;
        end
      end else begin
        r.val = val - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_ctrl_tick_prescaler.sv
// Free-run tick divider: counts while en,
// holds otherwise, clr restarts the period.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST =
    PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Phase counter, wraps after LAST.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/step/clear sequencer owning the
// counter register and wrap/done pulses.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 1000,
  parameter bit WRAP_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_step,
  input  logic             btn_clr,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             wrap,
  output logic             done
);

  localparam logic [31:0] MAXV =
    32'((64'd1 << WIDTH) - 64'd1);

  logic [1:0] nxt_state;
  logic       tick;
  logic       upd;
  logic       is_run;
  logic       is_idle;
  step_t      res;

  assign is_run  = (state == ST_RUN);
  assign is_idle = (state == ST_STOP) ||
                   (state == ST_PAUSE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (is_run),
    .clr (btn_clr || !is_run && !is_idle
          || state == ST_STOP),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STOP;
    end else begin
      state <= nxt_state;
    end
  end

  // Next state: clear beats mode beats
  // a saturating overrun in RUN.
  always_comb begin
    nxt_state = state;
    if (btn_clr) begin
      nxt_state = ST_STOP;
    end else begin
      unique case (state)
        ST_STOP: begin
          if (btn_mode) nxt_state = ST_RUN;
        end
        ST_RUN: begin
          if (btn_mode)
            nxt_state = ST_PAUSE;
          else if (tick && res.done)
            nxt_state = ST_STOP;
        end
        ST_PAUSE: begin
          if (btn_mode) nxt_state = ST_RUN;
        end
        default: nxt_state = ST_STOP;
      endcase
    end
  end

  // Count update request; a tick or step
  // coinciding with mode/clear is dropped.
  always_comb begin
    upd = 1'b0;
    res = next_count(32'(count), MAXV,
                     up_dn, WRAP_EN);
    if (!btn_clr && !btn_mode) begin
      unique case (1'b1)
        is_run:  upd = tick;
        is_idle: upd = btn_step;
        default: upd = 1'b0;
      endcase
    end
  end

  // Count and one-cycle flag registers.
  always_ff @(posedge clk) begin
    if (rst || btn_clr) begin
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (upd) begin
      count <= res.val[WIDTH-1:0];
      wrap  <= res.wrap;
      done  <= res.done;
    end else begin
      wrap  <= 1'b0;
      done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench: wrapping and saturating instances
// against a behavioural model.
module tb_counter_ctrl;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int M  = 1 << W;

  logic clk = 1'b0;
  logic rst, btn_mode, btn_step;
  logic btn_clr, up_dn;
  logic [W-1:0] count_w, count_s;
  logic [1:0]   state_w, state_s;
  logic wrap_w, wrap_s, done_w, done_s;

  always #5 clk = ~clk;

  counter_ctrl #(
    .WIDTH(W), .TICK_DIV(TD), .WRAP_EN(1'b1)
  ) dut_w (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_step(btn_step),
    .btn_clr(btn_clr), .up_dn(up_dn),
    .count(count_w), .state(state_w),
    .wrap(wrap_w), .done(done_w)
  );

  counter_ctrl #(
    .WIDTH(W), .TICK_DIV(TD), .WRAP_EN(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_step(btn_step),
    .btn_clr(btn_clr), .up_dn(up_dn),
    .count(count_s), .state(state_s),
    .wrap(wrap_s), .done(done_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Model: 0=stop 1=run 2=pause; ph is the
  // number of RUN cycles elapsed in the period.
  int m_cnt[2], m_st[2], m_ph[2];
  int m_wrap[2], m_done[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_st[i] = 0; m_ph[i] = 0;
      m_wrap[i] = 0; m_done[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit tk, go;
      int nph, a;
      if (rst) begin
        m_cnt[i] = 0; m_st[i] = 0; m_ph[i] = 0;
        m_wrap[i] = 0; m_done[i] = 0;
      end else begin
        m_wrap[i] = 0;
        m_done[i] = 0;
        tk = (m_st[i] == 1) && (m_ph[i] == TD - 1);
        if (btn_clr || m_st[i] == 0) nph = 0;
        else if (m_st[i] == 1) nph = (m_ph[i] + 1) % TD;
        else nph = m_ph[i];
        go = (m_st[i] == 1) ? tk : btn_step;
        if (btn_clr) begin
          m_cnt[i] = 0;
          m_st[i] = 0;
        end else if (btn_mode) begin
          m_st[i] = (m_st[i] == 1) ? 2 : 1;
        end else if (go) begin
          a = m_cnt[i] + (up_dn ? 1 : -1);
          if (a >= 0 && a < M) begin
            m_cnt[i] = a;
          end else if (i == 0) begin
            m_cnt[i] = (a + M) % M;
            m_wrap[i] = 1;
          end else begin
            m_done[i] = 1;
            if (m_st[i] == 1) m_st[i] = 0;
          end
        end
        m_ph[i] = nph;
      end
    end
  end

  task automatic check_all();
    check("cnt_w",  count_w, m_cnt[0]);
    check("st_w",   state_w, m_st[0]);
    check("wrap_w", wrap_w,  m_wrap[0]);
    check("done_w", done_w,  m_done[0]);
    check("cnt_s",  count_s, m_cnt[1]);
    check("st_s",   state_s, m_st[1]);
    check("wrap_s", wrap_s,  m_wrap[1]);
    check("done_s", done_s,  m_done[1]);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse(input logic m,
                       input logic s,
                       input logic c);
    btn_mode = m; btn_step = s; btn_clr = c;
    run_cycle();
    btn_mode = 0; btn_step = 0; btn_clr = 0;
  endtask

  initial begin
    rst = 1; btn_mode = 0; btn_step = 0;
    btn_clr = 0; up_dn = 1;
    run_cycle();
    run_cycle();
    rst = 0;
    for (int i = 0; i < 20; i++) run_cycle();
    check("idle_cnt", count_w, 0);
    check("idle_st", state_w, 0);

    for (int k = 1; k <= 3; k++) begin
      pulse(0, 1, 0);
      check("step_cnt", count_w, k);
      run_cycle();
    end
    pulse(0, 0, 1);

    pulse(1, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle();
    check("run_pre", count_w, 0);
    run_cycle();
    check("run_t4", count_w, 1);
    for (int i = 0; i < 4; i++) run_cycle();
    check("run_t8", count_w, 2);
    run_cycle();
    pulse(1, 0, 0);
    check("pause_st", state_w, 2);
    for (int i = 0; i < 7; i++) run_cycle();
    check("pause_hold", count_w, 2);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    check("run_step_ign", count_w, 2);
    run_cycle();
    check("resume_inc", count_w, 3);

    pulse(0, 0, 1);
    up_dn = 0;
    pulse(0, 1, 0);
    check("wrap_dn_cnt", count_w, 15);
    check("wrap_dn_p", wrap_w, 1);
    check("sat_dn_done", done_s, 1);
    run_cycle();
    check("wrap_1cyc", wrap_w, 0);
    up_dn = 1;
    pulse(0, 1, 0);
    check("wrap_up_cnt", count_w, 0);
    check("wrap_up_p", wrap_w, 1);

    pulse(0, 0, 1);
    for (int i = 0; i < 14; i++) pulse(0, 1, 0);
    check("sat_pre", count_s, 14);
    pulse(1, 0, 0);
    for (int i = 0; i < 4; i++) run_cycle();
    check("sat_15", count_s, 15);
    check("sat_15_nd", done_s, 0);
    for (int i = 0; i < 4; i++) run_cycle();
    check("sat_hold", count_s, 15);
    check("sat_done", done_s, 1);
    check("sat_stop", state_s, 0);
    run_cycle();
    check("sat_done1", done_s, 0);

    pulse(0, 0, 1);
    for (int i = 0; i < 9; i++) pulse(0, 1, 0);
    pulse(1, 0, 0);
    check("clr_pre", count_w, 9);
    pulse(1, 1, 1);
    check("clr_cnt", count_w, 0);
    check("clr_st", state_w, 0);
    pulse(1, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle();
    check("clr_pre0", count_w, 0);
    run_cycle();
    check("clr_tick", count_w, 1);
    run_cycle();
    rst = 1;
    btn_mode = 1; btn_step = 1;
    run_cycle();
    rst = 0; btn_mode = 0; btn_step = 0;
    check("rst_cnt", count_w, 0);
    check("rst_st", state_w, 0);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(99) == 0);
      btn_clr  = ($urandom_range(29) == 0);
      btn_mode = ($urandom_range(9) == 0);
      btn_step = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0)
        up_dn = ~up_dn;
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer for the button-driven 4-bit counter datapath. Consumes single-cycle command pulses (already debounced and edge-detected upstream) and owns the counter register. The FSM runs, pauses, single-steps or clears the count, using a prescaled tick for free-running mode. It sits between the debounce/posedge front end and the LED/7-seg display logic.

## Interface
- WIDTH, 4: counter width in bits.
- TICK_DIV, 1000: clk cycles per auto-count tick in RUN. Legal range is ≥ 2.
- WRAP_EN, 1: 1 means wrap at the limits; 0 means saturate at the limit, then drop to STOP.

- clk  in  1  system clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  one-cycle pulse: run/pause toggle.
- btn_step  in  1  one-cycle pulse: single step. Honoured only in STOP and PAUSE.
- btn_clr  in  1  one-cycle pulse: clear count and go to STOP.
- up_dn  in  1  level input. 1 counts up, 0 counts down. Sampled when a count update happens.
- count  out  WIDTH  registered counter value.
- state  out  2  FSM state (STOP=0, RUN=1, PAUSE=2).
- wrap  out  1  one-cycle pulse when the count wraps.
- done  out  1  one-cycle pulse when a saturating count (WRAP_EN=0) reaches its limit.

## Operation
- States and transitions:
  - STOP: btn_mode goes to RUN. btn_step counts ±1.
  - RUN: btn_mode goes to PAUSE. On each prescaler tick, count moves ±1.
  - PAUSE: btn_mode goes to RUN. btn_step counts ±1.
  - State encoding 3 is unreachable. If it ever occurs, go to STOP.
- Priority for the same cycle is btn_clr > btn_mode > btn_step.
  - btn_clr: count=0, state=STOP, prescaler=0. Any mode/step pulse in that cycle is dropped.
  - btn_mode with btn_step in STOP/PAUSE: the mode change wins and the step is dropped.
- btn_step in RUN is ignored.
- Up count update:
  - At 2^WIDTH-1 with WRAP_EN=1: count becomes 0 and wrap=1.
  - At 2^WIDTH-1 with WRAP_EN=0: count holds. done=1, and state goes to STOP if it was RUN.
- Down count update is symmetric at 0. With WRAP_EN=1, count becomes 2^WIDTH-1 and wrap=1.
- Reaching the limit (not attempting to pass it) with WRAP_EN=0 gives no done pulse. done fires on the attempted overrun.
- Prescaler behaviour:
  - Counts 0..TICK_DIV-1 only while state=RUN. It asserts tick in the cycle it holds TICK_DIV-1, then returns to 0.
  - Holds its value in PAUSE, so resuming continues the partial period.
  - Cleared to 0 in STOP and on btn_clr.
- Arithmetic is modulo 2^WIDTH. No carry beyond WIDTH.

## Timing
- Reset values: count=0, state=STOP, wrap=0, done=0, prescaler=0. Reset overrides every pulse in the same cycle.
- All outputs are registered. A pulse sampled at edge N shows its effect on count/state after edge N, i.e. in cycle N+1.
- wrap and done are high for exactly one cycle, the same cycle the corresponding count/state update becomes visible.
- Free-run latency: with btn_mode sampled at edge 0 (STOP→RUN), the first count change is visible after edge TICK_DIV. Later changes follow every TICK_DIV cycles.
- Pause/resume: cycles spent in PAUSE do not count toward the tick period.
- Reset mid-RUN discards any partial prescaler period.

## Structure
- Package counter_ctrl_pkg holds:
  - localparams for the state encoding: ST_STOP, ST_RUN, ST_PAUSE.
  - a helper function for next count given value, direction and WRAP_EN. It returns the value plus wrap/done flags.
- One sub-module: tick_prescaler.
  - Parameter TICK_DIV.
  - Ports clk, rst, en, clr, tick.
  - Counter width is $clog2(TICK_DIV).
- counter_ctrl contains the FSM, the count register and the pulse registers.

## Test plan
Bench uses TICK_DIV=4, WIDTH=4 unless stated.
- Reset then idle 20 cycles -> count=0, state=0, wrap=done=0 throughout.
- STOP, up_dn=1, three btn_step pulses -> count 1,2,3, each one cycle after its pulse. btn_step while in RUN -> count unchanged by the step.
- btn_mode at cycle 0, up_dn=1 -> count=1 visible at cycle 4, 2 at cycle 8. btn_mode at cycle 10 -> PAUSE. Hold 7 cycles, resume -> next increment after the 2 remaining prescaler cycles.
- WRAP_EN=1, count=15, up step -> count=0 with a 1-cycle wrap. Down step from 0 -> count=15 with wrap.
- WRAP_EN=0, RUN up from 14 -> 15 at the next tick. On the following tick: count stays 15, done pulses once, state=STOP.
- btn_clr+btn_mode+btn_step in the same cycle during RUN at count=9 -> count=0, state=STOP, prescaler restarts from 0 on the next RUN. Then rst asserted during RUN -> all reset values the next cycle.
